// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage 16-bit pipeline: stage enables,
// IF/ID flush, PC redirect, shared-RAM arbitration and branch deferral across fetch stalls.
//
// state | meaning
// BOOT  | post-reset hold, all enables low until the boot down-counter expires
// RUN   | normal issue; load-use and shared-RAM stalls handled in place
// PEND  | taken branch seen during a fetch stall; redirect to tgt_q on first free cycle
module pipeline_ctrl #(
   parameter int BOOT_CYCLES = 4
) (
   input  logic        pci_clk,
   input  logic        pci_rst,
   input  logic [3:0]  pci_id_rs_addr,
   input  logic        pci_id_rs_used,
   input  logic [3:0]  pci_id_rt_addr,
   input  logic        pci_id_rt_used,
   input  logic        pci_branch_taken,
   input  logic [15:0] pci_branch_target,
   input  logic [3:0]  pci_ex_wreg_addr,
   input  logic [1:0]  pci_ex_rwe,
   input  logic [1:0]  pci_mem_rwe,
   input  logic        pci_mem_shared,
   output logic        pco_pc_en,
   output logic        pco_if_id_en,
   output logic        pco_id_exe_en,
   output logic        pco_exe_mem_en,
   output logic        pco_mem_wb_en,
   output logic        pco_if_id_flush,
   output logic        pco_pc_redirect,
   output logic [15:0] pco_pc_target,
   output logic        pco_bus_mem,
   output logic [15:0] pco_stall_cnt,
   output logic [1:0]  pco_state
);

   localparam logic [1:0] RWE_IDLE    = 2'b00;
   localparam logic [1:0] RWE_READ    = 2'b01;
   localparam logic [3:0] REG_INVALID = 4'h0;
   localparam logic [7:0] BOOT_LOAD   = 8'(BOOT_CYCLES);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  boot_q, boot_d;
   logic [15:0] tgt_q, tgt_d;
   logic [15:0] stall_q, stall_d;
   logic        lu, sc, bt;

   always_comb begin
      lu = (pci_ex_rwe == RWE_READ) && (pci_ex_wreg_addr != REG_INVALID) &&
           ((pci_id_rs_used && (pci_id_rs_addr == pci_ex_wreg_addr)) ||
            (pci_id_rt_used && (pci_id_rt_addr == pci_ex_wreg_addr)));
      sc = (pci_mem_rwe != RWE_IDLE) && pci_mem_shared;
      bt = pci_branch_taken && !lu;
   end

   always_ff @(posedge pci_clk) begin
      if (pci_rst) begin
         state_q <= ST_BOOT;
         boot_q  <= BOOT_LOAD;
         tgt_q   <= 16'h0000;
         stall_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         boot_q  <= boot_d;
         tgt_q   <= tgt_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      boot_d          = boot_q;
      tgt_d           = tgt_q;
      stall_d         = stall_q;
      pco_pc_en       = 1'b0;
      pco_if_id_en    = 1'b0;
      pco_id_exe_en   = 1'b0;
      pco_exe_mem_en  = 1'b0;
      pco_mem_wb_en   = 1'b0;
      pco_if_id_flush = 1'b0;
      pco_pc_redirect = 1'b0;
      pco_pc_target   = pci_branch_target;
      pco_bus_mem     = 1'b0;

      case (state_q)
         ST_BOOT: begin
            if (boot_q == 8'd1) state_d = ST_RUN;
            else                boot_d  = boot_q - 8'd1;
         end

         ST_RUN: begin
            pco_bus_mem = sc;
            if (lu) begin
               pco_exe_mem_en = 1'b1;
               pco_mem_wb_en  = 1'b1;
            end else if (sc) begin
               pco_if_id_en    = 1'b1;
               pco_id_exe_en   = 1'b1;
               pco_exe_mem_en  = 1'b1;
               pco_mem_wb_en   = 1'b1;
               pco_if_id_flush = 1'b1;
               // Delay slot not yet fetched, so the redirect has to wait.
               if (bt) begin
                  tgt_d   = pci_branch_target;
                  state_d = ST_PEND;
               end
            end else begin
               pco_pc_en       = 1'b1;
               pco_if_id_en    = 1'b1;
               pco_id_exe_en   = 1'b1;
               pco_exe_mem_en  = 1'b1;
               pco_mem_wb_en   = 1'b1;
               pco_pc_redirect = bt;
            end
         end

         ST_PEND: begin
            pco_bus_mem    = sc;
            pco_pc_target  = tgt_q;
            pco_if_id_en   = 1'b1;
            pco_id_exe_en  = 1'b1;
            pco_exe_mem_en = 1'b1;
            pco_mem_wb_en  = 1'b1;
            if (sc) begin
               pco_if_id_flush = 1'b1;
            end else begin
               pco_pc_en       = 1'b1;
               pco_pc_redirect = 1'b1;
               state_d         = ST_RUN;
            end
         end

         default: state_d = ST_BOOT;
      endcase

      if ((state_q != ST_BOOT) && (lu || sc) && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'h0001;
   end

   assign pco_stall_cnt = stall_q;
   assign pco_state     = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

   localparam int         BOOT_CYCLES = 4;
   localparam logic [1:0] RWE_IDLE    = 2'b00;
   localparam logic [1:0] RWE_READ    = 2'b01;
   localparam logic [1:0] RWE_WRITE   = 2'b10;
   localparam logic [3:0] REG_INVALID = 4'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rs, rt, ex_wreg;
   logic        rs_used, rt_used, branch;
   logic [15:0] btarget;
   logic [1:0]  ex_rwe, mem_rwe;
   logic        mem_shared;
   logic        pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
   logic        flush, redirect, bus_mem;
   logic [15:0] pc_target, stall_cnt;
   logic [1:0]  state;
   logic [7:0]  dut_ctl;

   int checks = 0;
   int errors = 0;

   // Model: mode 0=boot 1=run 2=pending-branch
   bit          m_valid = 0;
   int          m_mode;
   int          m_boot_elapsed;
   logic [15:0] m_tgt;
   int          m_cnt;

   pipeline_ctrl #(.BOOT_CYCLES(BOOT_CYCLES)) dut (
      .pci_clk(clk), .pci_rst(rst),
      .pci_id_rs_addr(rs), .pci_id_rs_used(rs_used),
      .pci_id_rt_addr(rt), .pci_id_rt_used(rt_used),
      .pci_branch_taken(branch), .pci_branch_target(btarget),
      .pci_ex_wreg_addr(ex_wreg), .pci_ex_rwe(ex_rwe),
      .pci_mem_rwe(mem_rwe), .pci_mem_shared(mem_shared),
      .pco_pc_en(pc_en), .pco_if_id_en(if_id_en), .pco_id_exe_en(id_exe_en),
      .pco_exe_mem_en(exe_mem_en), .pco_mem_wb_en(mem_wb_en),
      .pco_if_id_flush(flush), .pco_pc_redirect(redirect),
      .pco_pc_target(pc_target), .pco_bus_mem(bus_mem),
      .pco_stall_cnt(stall_cnt), .pco_state(state)
   );

   always #5 clk = ~clk;

   assign dut_ctl = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, flush, redirect, bus_mem};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit f_lu();
      return (ex_rwe == RWE_READ) && (ex_wreg != REG_INVALID) &&
             ((rs_used && rs == ex_wreg) || (rt_used && rt == ex_wreg));
   endfunction

   function automatic bit f_sc();
      return (mem_rwe != RWE_IDLE) && mem_shared;
   endfunction

   task automatic sample();
      logic [7:0]  e_ctl;
      logic [15:0] e_tgt;
      bit lu, sc;
      @(negedge clk);
      if (m_valid) begin
         lu    = f_lu();
         sc    = f_sc();
         e_tgt = (m_mode == 2) ? m_tgt : btarget;
         // {pc, if_id, id_exe, exe_mem, mem_wb, flush, redirect, bus_mem}
         if (m_mode == 0)            e_ctl = 8'b00000000;
         else if (m_mode == 1 && lu) e_ctl = {7'b0001100, sc};
         else if (sc)                e_ctl = 8'b01111101;
         else if (m_mode == 2)       e_ctl = 8'b11111010;
         else if (branch)            e_ctl = 8'b11111010;
         else                        e_ctl = 8'b11111000;
         chk("model_ctl", 32'(dut_ctl), 32'(e_ctl));
         chk("model_target", 32'(pc_target), 32'(e_tgt));
         chk("model_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
         chk("model_state", 32'(state), 32'(m_mode));
      end
   endtask

   task automatic advance();
      bit lu, sc;
      lu = f_lu();
      sc = f_sc();
      if (rst) begin
         m_valid = 1; m_mode = 0; m_boot_elapsed = 0; m_tgt = 16'h0; m_cnt = 0;
      end else if (m_valid) begin
         if (m_mode == 0) begin
            m_boot_elapsed++;
            if (m_boot_elapsed == BOOT_CYCLES) m_mode = 1;
         end else begin
            if (lu || sc) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (m_mode == 1 && !lu && sc && branch) begin
               m_tgt  = btarget;
               m_mode = 2;
            end else if (m_mode == 2 && !sc) begin
               m_mode = 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      sample();
      advance();
   endtask

   task automatic idle();
      rs = 4'h5; rt = 4'h6; rs_used = 0; rt_used = 0;
      branch = 0; btarget = 16'hBEEF;
      ex_wreg = REG_INVALID; ex_rwe = RWE_IDLE;
      mem_rwe = RWE_IDLE; mem_shared = 0;
   endtask

   task automatic set_lu();
      ex_rwe = RWE_READ; ex_wreg = 4'd3; rs_used = 1; rs = 4'd3;
   endtask

   task automatic set_sc();
      mem_rwe = RWE_WRITE; mem_shared = 1;
   endtask

   initial begin
      idle();
      rst = 1;
      @(posedge clk); #1;
      cyc();
      rst = 0;

      for (int i = 1; i <= BOOT_CYCLES; i++) begin
         sample();
         chk("boot_state", 32'(state), 0);
         chk("boot_enables", 32'({pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en}), 0);
         advance();
      end
      sample();
      chk("run_state", 32'(state), 1);
      chk("run_ctl", 32'(dut_ctl), 32'h F8);
      chk("run_stall0", 32'(stall_cnt), 0);
      advance();

      set_lu();
      sample();
      chk("lu_enables", 32'({pc_en, if_id_en, id_exe_en, exe_mem_en}), 32'b0001);
      advance();
      idle();
      sample();
      chk("lu_stall_cnt", 32'(stall_cnt), 1);
      advance();
      ex_rwe = RWE_READ; ex_wreg = REG_INVALID; rs_used = 1; rs = REG_INVALID;
      sample();
      chk("lu_invalid_pc_en", 32'(pc_en), 1);
      advance();
      idle();

      set_sc();
      repeat (3) begin
         sample();
         chk("sc_bus_flush_pc", 32'({bus_mem, flush, pc_en}), 32'b110);
         advance();
      end
      mem_shared = 0;
      sample();
      chk("sc_off_pc_en", 32'(pc_en), 1);
      chk("sc_stall_cnt", 32'(stall_cnt), 4);
      advance();
      idle();

      branch = 1; btarget = 16'h0040;
      sample();
      chk("bt_redirect", 32'({redirect, flush}), 32'b10);
      chk("bt_target", 32'(pc_target), 32'h0040);
      advance();
      idle();

      branch = 1; btarget = 16'h1234; set_sc();
      sample();
      chk("pend_entry_flush", 32'(flush), 1);
      advance();
      idle();
      sample();
      chk("pend_state", 32'(state), 2);
      chk("pend_redirect", 32'(redirect), 1);
      chk("pend_target", 32'(pc_target), 32'h1234);
      advance();
      sample();
      chk("pend_exit_state", 32'(state), 1);
      advance();

      branch = 1; btarget = 16'h5678; set_sc();
      cyc();
      branch = 0;
      repeat (2) begin
         sample();
         chk("pend_sc_hold", 32'({state, redirect}), 32'b100);
         advance();
      end
      mem_shared = 0;
      sample();
      chk("pend_late_redirect", 32'(redirect), 1);
      chk("pend_late_target", 32'(pc_target), 32'h5678);
      advance();
      idle();

      set_lu(); branch = 1; btarget = 16'h9999;
      sample();
      chk("lu_branch_ignored", 32'({redirect, pc_en}), 0);
      advance();
      idle();

      branch = 1; btarget = 16'hABCD; set_sc();
      cyc();
      branch = 0;
      rst = 1;
      cyc();
      rst = 0;
      idle();
      sample();
      chk("rst_pend_state", 32'(state), 0);
      chk("rst_pend_redirect", 32'(redirect), 0);
      advance();
      repeat (BOOT_CYCLES + 2) cyc();

      repeat (3000) begin
         rs         = 4'($urandom_range(0, 3));
         rt         = 4'($urandom_range(0, 3));
         rs_used    = 1'($urandom_range(0, 1));
         rt_used    = 1'($urandom_range(0, 1));
         ex_wreg    = 4'($urandom_range(0, 3));
         ex_rwe     = 2'($urandom_range(0, 3));
         mem_rwe    = 2'($urandom_range(0, 3));
         mem_shared = ($urandom_range(0, 2) == 0);
         branch     = ($urandom_range(0, 3) == 0);
         btarget    = 16'($urandom);
         rst        = ($urandom_range(0, 149) == 0);
         cyc();
      end
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
